// File: rtl/iommu_mmio_pkg.sv
// Shared definitions for the IOMMU MMIO block: register map, DDTP modes, QCSR bit
// positions, capability constant and APB FSM encoding.
package iommu_mmio_pkg;

  localparam logic [11:0] OffCaps  = 12'h000;
  localparam logic [11:0] OffFctl  = 12'h008;
  localparam logic [11:0] OffDdtp  = 12'h010;
  localparam logic [11:0] OffQBase = 12'h018;
  localparam logic [11:0] QStride  = 12'h010;
  localparam logic [11:0] QHeadOff = 12'h008;
  localparam logic [11:0] QTailOff = 12'h00C;
  localparam logic [11:0] OffQcsr  = 12'h048;
  localparam logic [11:0] OffIpsr  = 12'h054;

  typedef enum logic [3:0] {
    ModeOff  = 4'd0,
    ModeBare = 4'd1,
    Mode1Lvl = 4'd2,
    Mode2Lvl = 4'd3,
    Mode3Lvl = 4'd4
  } ddtp_mode_e;

  localparam int unsigned DdtpBusyBit = 4;
  localparam int unsigned PpnLsb      = 10;

  localparam int unsigned QcsrEn   = 0;
  localparam int unsigned QcsrIe   = 1;
  localparam int unsigned QcsrMemf = 8;
  localparam int unsigned QcsrOn   = 16;
  localparam int unsigned QcsrBusy = 17;

  localparam logic [63:0] CapsVal = 64'h0000_0000_0000_0010;

  typedef enum logic [1:0] {StIdle, StWait, StDone} apb_st_e;

endpackage

// File: rtl/iommu_mmio_qregs.sv
// One in-memory queue register set: base, SW/HW indices, CSR and enable handshake.
module iommu_mmio_qregs
  import iommu_mmio_pkg::*;
#(
  parameter int unsigned PpnW   = 34,
  parameter int unsigned IdxW   = 20,
  parameter bit          SwProd = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            qb_we_i,
  input  logic            head_we_i,
  input  logic            tail_we_i,
  input  logic            csr_we_i,
  input  logic [63:0]     wdata_i,
  input  logic            ack_i,
  input  logic            hw_we_i,
  input  logic [IdxW-1:0] hw_idx_i,
  input  logic            memf_i,
  output logic [PpnW-1:0] ppn_o,
  output logic [4:0]      log2sz_o,
  output logic            on_o,
  output logic            busy_o,
  output logic            ie_o,
  output logic [IdxW-1:0] sw_idx_o,
  output logic [63:0]     qb_o,
  output logic [31:0]     head_o,
  output logic [31:0]     tail_o,
  output logic [31:0]     csr_o
);

  logic [PpnW-1:0] ppn_q;
  logic [4:0]      log2sz_q;
  logic [IdxW-1:0] sw_idx_q, hw_idx_q, mask;
  logic            en_q, on_q, busy_q, ie_q, memf_q;
  logic            sw_we;
  logic            unused_wdata;

  assign sw_we        = SwProd ? tail_we_i : head_we_i;
  assign unused_wdata = ^wdata_i[63:PpnW+PpnLsb];

  // Index mask (2 << log2sz) - 1, saturating to all-ones for large sizes.
  always_comb begin
    mask = '0;
    for (int b = 0; b < int'(IdxW); b++) mask[b] = (b <= int'(log2sz_q));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ppn_q    <= '0;
      log2sz_q <= '0;
      sw_idx_q <= '0;
      hw_idx_q <= '0;
      en_q     <= 1'b0;
      on_q     <= 1'b0;
      busy_q   <= 1'b0;
      ie_q     <= 1'b0;
      memf_q   <= 1'b0;
    end else begin
      if (qb_we_i && !on_q && !busy_q) begin
        log2sz_q <= wdata_i[4:0];
        ppn_q    <= wdata_i[PpnW+PpnLsb-1:PpnLsb];
      end
      if (sw_we) sw_idx_q <= wdata_i[IdxW-1:0] & mask;
      if (ack_i && busy_q) begin
        on_q   <= en_q;
        busy_q <= 1'b0;
      end
      // Enabling a queue restarts the HW-owned index, overriding any same-cycle HW load.
      if (ack_i && busy_q && en_q) hw_idx_q <= '0;
      else if (hw_we_i)            hw_idx_q <= hw_idx_i & mask;
      if (csr_we_i) begin
        ie_q <= wdata_i[QcsrIe];
        if (!busy_q && (wdata_i[QcsrEn] != on_q)) begin
          en_q   <= wdata_i[QcsrEn];
          busy_q <= 1'b1;
        end
      end
      memf_q <= memf_i | (memf_q & ~(csr_we_i & wdata_i[QcsrMemf]));
    end
  end

  always_comb begin
    qb_o                             = '0;
    qb_o[4:0]                        = log2sz_q;
    qb_o[PpnW+PpnLsb-1:PpnLsb]       = ppn_q;
    csr_o                            = '0;
    csr_o[QcsrEn]                    = en_q;
    csr_o[QcsrIe]                    = ie_q;
    csr_o[QcsrMemf]                  = memf_q;
    csr_o[QcsrOn]                    = on_q;
    csr_o[QcsrBusy]                  = busy_q;
  end

  assign head_o   = SwProd ? 32'(hw_idx_q) : 32'(sw_idx_q);
  assign tail_o   = SwProd ? 32'(sw_idx_q) : 32'(hw_idx_q);
  assign ppn_o    = ppn_q;
  assign log2sz_o = log2sz_q;
  assign on_o     = on_q;
  assign busy_o   = busy_q;
  assign ie_o     = ie_q;
  assign sw_idx_o = sw_idx_q;

endmodule

// File: rtl/iommu_mmio_queues.sv
// APB slave for DDTP plus NUM_Q queue register sets, with busy/ack handshakes.
// Optional IPSR/interrupt logic is built when IOMMU_MMIO_IPSR_EN is defined.
module iommu_mmio_queues
  import iommu_mmio_pkg::*;
#(
  parameter int unsigned PPN_W   = 34,
  parameter int unsigned NUM_Q   = 3,
  parameter int unsigned IDX_W   = 20,
  parameter logic [2:0]  SW_PROD = 3'b001
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [11:0]            paddr,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [63:0]            pwdata,
  output logic [63:0]            prdata,
  output logic                   pready,
  output logic                   pslverr,
  output logic [3:0]             ddtp_mode_o,
  output logic [PPN_W-1:0]       ddtp_ppn_o,
  output logic                   ddtp_busy_o,
  input  logic                   ddtp_idle_i,
  output logic [NUM_Q*PPN_W-1:0] q_ppn_o,
  output logic [NUM_Q*5-1:0]     q_log2sz_o,
  output logic [NUM_Q-1:0]       q_on_o,
  output logic [NUM_Q-1:0]       q_busy_o,
  input  logic [NUM_Q-1:0]       q_ack_i,
  output logic [NUM_Q*IDX_W-1:0] q_sw_idx_o,
  input  logic [NUM_Q*IDX_W-1:0] q_hw_idx_i,
  input  logic [NUM_Q-1:0]       q_hw_we_i,
  input  logic [NUM_Q-1:0]       q_memf_i,
  input  logic [NUM_Q-1:0]       q_int_i,
  output logic                   irq_o
);

  apb_st_e          st_q;
  logic [11:0]      addr_q;
  logic             wr_q, pready_q, pslverr_q, commit;
  logic [63:0]      prdata_q, dec_rdata, ddtp_rd;
  logic             dec_hit, ddtp_sel;
  logic [NUM_Q-1:0] qb_sel, head_sel, tail_sel, csr_sel, q_ie;
  logic [3:0]       ddtp_mode_q, shadow_mode_q;
  logic [PPN_W-1:0] ddtp_ppn_q, shadow_ppn_q;
  logic             ddtp_busy_q;
  logic [63:0]      q_qb_rd   [NUM_Q];
  logic [31:0]      q_head_rd [NUM_Q];
  logic [31:0]      q_tail_rd [NUM_Q];
  logic [31:0]      q_csr_rd  [NUM_Q];

`ifdef IOMMU_MMIO_IPSR_EN
  logic [NUM_Q-1:0] ipsr_q;
  logic             irq_q, ipsr_sel;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= StIdle;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      unique case (st_q)
        StIdle: if (psel && !penable) begin
          st_q   <= StWait;
          addr_q <= paddr;
          wr_q   <= pwrite;
        end
        StWait: if (!psel) begin
          st_q <= StIdle;
        end else begin
          st_q      <= StDone;
          pready_q  <= 1'b1;
          pslverr_q <= !dec_hit;
          prdata_q  <= (dec_hit && !wr_q) ? dec_rdata : '0;
        end
        StDone:  st_q <= StIdle;
        default: st_q <= StIdle;
      endcase
    end
  end

  assign commit = (st_q == StDone) && wr_q;

  always_comb begin
    ddtp_rd                            = '0;
    ddtp_rd[3:0]                       = ddtp_mode_q;
    ddtp_rd[DdtpBusyBit]               = ddtp_busy_q;
    ddtp_rd[PPN_W+PpnLsb-1:PpnLsb]     = ddtp_ppn_q;
  end

  // Only exact, aligned register addresses hit; everything else is a slave error.
  always_comb begin
    dec_hit   = 1'b0;
    dec_rdata = '0;
    ddtp_sel  = 1'b0;
    qb_sel    = '0;
    head_sel  = '0;
    tail_sel  = '0;
    csr_sel   = '0;
`ifdef IOMMU_MMIO_IPSR_EN
    ipsr_sel  = 1'b0;
    if (addr_q == OffIpsr) begin
      dec_hit   = 1'b1;
      ipsr_sel  = 1'b1;
      dec_rdata = 64'(ipsr_q);
    end
`endif
    if (addr_q == OffCaps) begin
      dec_hit   = 1'b1;
      dec_rdata = CapsVal;
    end
    if (addr_q == OffFctl) dec_hit = 1'b1;
    if (addr_q == OffDdtp) begin
      dec_hit   = 1'b1;
      ddtp_sel  = 1'b1;
      dec_rdata = ddtp_rd;
    end
    for (int i = 0; i < int'(NUM_Q); i++) begin
      if (addr_q == OffQBase + QStride * 12'(i)) begin
        dec_hit   = 1'b1;
        qb_sel[i] = 1'b1;
        dec_rdata = q_qb_rd[i];
      end
      if (addr_q == OffQBase + QStride * 12'(i) + QHeadOff) begin
        dec_hit     = 1'b1;
        head_sel[i] = 1'b1;
        dec_rdata   = 64'(q_head_rd[i]);
      end
      if (addr_q == OffQBase + QStride * 12'(i) + QTailOff) begin
        dec_hit     = 1'b1;
        tail_sel[i] = 1'b1;
        dec_rdata   = 64'(q_tail_rd[i]);
      end
      if (addr_q == OffQcsr + 12'(4 * i)) begin
        dec_hit    = 1'b1;
        csr_sel[i] = 1'b1;
        dec_rdata  = 64'(q_csr_rd[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ddtp_mode_q   <= '0;
      ddtp_ppn_q    <= '0;
      ddtp_busy_q   <= 1'b0;
      shadow_mode_q <= '0;
      shadow_ppn_q  <= '0;
    end else if (commit && ddtp_sel && !ddtp_busy_q && (pwdata[3:0] <= Mode3Lvl)) begin
      ddtp_mode_q <= pwdata[3:0];
      ddtp_ppn_q  <= pwdata[PPN_W+PpnLsb-1:PpnLsb];
      ddtp_busy_q <= 1'b1;
    end else if (ddtp_busy_q && ddtp_idle_i) begin
      shadow_mode_q <= ddtp_mode_q;
      shadow_ppn_q  <= ddtp_ppn_q;
      ddtp_busy_q   <= 1'b0;
    end
  end

  for (genvar g = 0; g < int'(NUM_Q); g++) begin : gen_q
    iommu_mmio_qregs #(
      .PpnW  (PPN_W),
      .IdxW  (IDX_W),
      .SwProd(SW_PROD[g])
    ) u_qregs (
      .clk_i    (clk),
      .rst_i    (rst),
      .qb_we_i  (commit & qb_sel[g]),
      .head_we_i(commit & head_sel[g]),
      .tail_we_i(commit & tail_sel[g]),
      .csr_we_i (commit & csr_sel[g]),
      .wdata_i  (pwdata),
      .ack_i    (q_ack_i[g]),
      .hw_we_i  (q_hw_we_i[g]),
      .hw_idx_i (q_hw_idx_i[g*IDX_W +: IDX_W]),
      .memf_i   (q_memf_i[g]),
      .ppn_o    (q_ppn_o[g*PPN_W +: PPN_W]),
      .log2sz_o (q_log2sz_o[g*5 +: 5]),
      .on_o     (q_on_o[g]),
      .busy_o   (q_busy_o[g]),
      .ie_o     (q_ie[g]),
      .sw_idx_o (q_sw_idx_o[g*IDX_W +: IDX_W]),
      .qb_o     (q_qb_rd[g]),
      .head_o   (q_head_rd[g]),
      .tail_o   (q_tail_rd[g]),
      .csr_o    (q_csr_rd[g])
    );
  end

`ifdef IOMMU_MMIO_IPSR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ipsr_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      ipsr_q <= q_int_i | (ipsr_q & ~({NUM_Q{commit & ipsr_sel}} & pwdata[NUM_Q-1:0]));
      irq_q  <= |(ipsr_q & q_ie);
    end
  end
  assign irq_o = irq_q;
`else
  logic unused_int;
  assign unused_int = ^{q_int_i, q_ie};
  assign irq_o      = 1'b0;
`endif

  assign prdata      = prdata_q;
  assign pready      = pready_q;
  assign pslverr     = pslverr_q;
  assign ddtp_mode_o = shadow_mode_q;
  assign ddtp_ppn_o  = shadow_ppn_q;
  assign ddtp_busy_o = ddtp_busy_q;

endmodule

// File: tb/tb_iommu_mmio_queues.sv
// Directed bench for iommu_mmio_queues with hand-computed expectations.
module tb_iommu_mmio_queues;

  localparam int PPN_W = 34;
  localparam int NUM_Q = 3;
  localparam int IDX_W = 20;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [11:0]            paddr;
  logic                   psel, penable, pwrite;
  logic [63:0]            pwdata, prdata;
  logic                   pready, pslverr;
  logic [3:0]             ddtp_mode_o;
  logic [PPN_W-1:0]       ddtp_ppn_o;
  logic                   ddtp_busy_o, ddtp_idle_i;
  logic [NUM_Q*PPN_W-1:0] q_ppn_o;
  logic [NUM_Q*5-1:0]     q_log2sz_o;
  logic [NUM_Q-1:0]       q_on_o, q_busy_o, q_ack_i, q_hw_we_i, q_memf_i, q_int_i;
  logic [NUM_Q*IDX_W-1:0] q_sw_idx_o, q_hw_idx_i;
  logic                   irq_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  iommu_mmio_queues #(
    .PPN_W  (PPN_W),
    .NUM_Q  (NUM_Q),
    .IDX_W  (IDX_W),
    .SW_PROD(3'b001)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .paddr      (paddr),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .ddtp_mode_o(ddtp_mode_o),
    .ddtp_ppn_o (ddtp_ppn_o),
    .ddtp_busy_o(ddtp_busy_o),
    .ddtp_idle_i(ddtp_idle_i),
    .q_ppn_o    (q_ppn_o),
    .q_log2sz_o (q_log2sz_o),
    .q_on_o     (q_on_o),
    .q_busy_o   (q_busy_o),
    .q_ack_i    (q_ack_i),
    .q_sw_idx_o (q_sw_idx_o),
    .q_hw_idx_i (q_hw_idx_i),
    .q_hw_we_i  (q_hw_we_i),
    .q_memf_i   (q_memf_i),
    .q_int_i    (q_int_i),
    .irq_o      (irq_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One APB transfer; memf_d/int_d are driven during the DONE (commit) cycle.
  task automatic apb_xfer(input logic [11:0] a, input logic w, input logic [63:0] d,
                          input logic [2:0] memf_d, input logic [2:0] int_d,
                          output logic [63:0] rd, output logic err, output int lat);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d; lat = 1;
    @(posedge clk); #1;
    penable = 1'b1; lat = 2;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!pready && lat < 8);
    check("pready", 64'(pready), 64'd1);
    rd = prdata; err = pslverr;
    psel = 1'b0; penable = 1'b0;
    q_memf_i = memf_d; q_int_i = int_d;
    @(posedge clk); #1;
    q_memf_i = '0; q_int_i = '0;
  endtask

  task automatic apb_rd(input logic [11:0] a, output logic [63:0] rd, output logic err);
    int lat;
    apb_xfer(a, 1'b0, 64'd0, 3'b000, 3'b000, rd, err, lat);
  endtask

  task automatic apb_wr(input logic [11:0] a, input logic [63:0] d, output logic err);
    logic [63:0] rd;
    int lat;
    apb_xfer(a, 1'b1, d, 3'b000, 3'b000, rd, err, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    logic err;
    int lat;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    ddtp_idle_i = 1'b0; q_ack_i = '0; q_hw_we_i = '0; q_hw_idx_i = '0; q_memf_i = '0;
    q_int_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", 64'({pready, pslverr, irq_o, ddtp_busy_o, q_on_o, q_busy_o}), 64'd0);
    check("rst_prdata", prdata, 64'd0);
    check("rst_ddtp", 64'({ddtp_mode_o, ddtp_ppn_o}), 64'd0);
    rst = 1'b0;

    // CAPS read latency and value, then an unmapped offset.
    apb_xfer(12'h000, 1'b0, 64'd0, 3'b000, 3'b000, rd, err, lat);
    check("caps_lat", 64'(lat), 64'd3);
    check("caps_val", rd, 64'h10);
    check("caps_err", 64'(err), 64'd0);
    apb_rd(12'h004, rd, err);
    check("unmap_err", 64'(err), 64'd1);
    check("unmap_data", rd, 64'd0);

    // DDTP handshake.
    apb_wr(12'h010, 64'h48C04, err);
    check("ddtp_wr_err", 64'(err), 64'd0);
    check("ddtp_busy", 64'(ddtp_busy_o), 64'd1);
    check("ddtp_hold", 64'({ddtp_mode_o, ddtp_ppn_o}), 64'd0);
    apb_wr(12'h010, 64'h1DC03, err);
    apb_rd(12'h010, rd, err);
    check("ddtp_rd_busy", rd, 64'h48C14);
    ddtp_idle_i = 1'b1;
    @(posedge clk); #1;
    ddtp_idle_i = 1'b0;
    check("ddtp_mode", 64'(ddtp_mode_o), 64'd4);
    check("ddtp_ppn", 64'(ddtp_ppn_o), 64'h123);
    check("ddtp_unbusy", 64'(ddtp_busy_o), 64'd0);
    apb_wr(12'h010, 64'h2407, err);
    check("ddtp_m7_err", 64'(err), 64'd0);
    apb_rd(12'h010, rd, err);
    check("ddtp_m7_rd", rd, 64'h48C04);
    check("ddtp_m7_busy", 64'(ddtp_busy_o), 64'd0);
    apb_wr(12'h012, 64'h0, err);
    check("ddtp_misal", 64'(err), 64'd1);

    // Queue 0: software-produced, HW owns head.
    apb_wr(12'h018, 64'h15403, err);
    check("q0_ppn", 64'(q_ppn_o[PPN_W-1:0]), 64'h55);
    check("q0_lsz", 64'(q_log2sz_o[4:0]), 64'd3);
    apb_wr(12'h048, 64'h1, err);
    check("q0_busy", 64'({q_on_o[0], q_busy_o[0]}), 64'b01);
    apb_rd(12'h048, rd, err);
    check("q0_csr_busy", rd, 64'h20001);
    q_hw_idx_i[IDX_W-1:0] = 20'h5; q_hw_we_i = 3'b001;
    @(posedge clk); #1;
    q_hw_we_i = '0;
    apb_rd(12'h020, rd, err);
    check("q0_head_hw", rd, 64'h5);
    q_ack_i = 3'b001;
    @(posedge clk); #1;
    q_ack_i = '0;
    check("q0_on", 64'({q_on_o[0], q_busy_o[0]}), 64'b10);
    apb_rd(12'h020, rd, err);
    check("q0_head_clr", rd, 64'h0);
    apb_rd(12'h048, rd, err);
    check("q0_csr_on", rd, 64'h10001);
    apb_wr(12'h024, 64'h1F, err);
    check("q0_swidx", 64'(q_sw_idx_o[IDX_W-1:0]), 64'hF);
    apb_rd(12'h024, rd, err);
    check("q0_tail_rd", rd, 64'hF);
    apb_wr(12'h018, 64'h19802, err);
    apb_rd(12'h018, rd, err);
    check("q0_qb_locked", rd, 64'h15403);
    apb_wr(12'h020, 64'h7, err);
    check("q0_head_ro_err", 64'(err), 64'd0);
    apb_rd(12'h020, rd, err);
    check("q0_head_ro", rd, 64'h0);
    apb_rd(12'h01C, rd, err);
    check("q0_qb_misal", 64'({err, rd[31:0]}), 64'h1_0000_0000);

    // Queue 1: HW-produced, HW owns tail.
    apb_wr(12'h028, 64'h1, err);
    q_hw_idx_i[2*IDX_W-1:IDX_W] = 20'h7; q_hw_we_i = 3'b010;
    @(posedge clk); #1;
    q_hw_we_i = '0;
    apb_rd(12'h034, rd, err);
    check("q1_tail_mask", rd, 64'h3);
    apb_wr(12'h030, 64'h6, err);
    check("q1_swidx", 64'(q_sw_idx_o[2*IDX_W-1:IDX_W]), 64'h2);
    q_memf_i = 3'b010;
    @(posedge clk); #1;
    q_memf_i = '0;
    apb_rd(12'h04C, rd, err);
    check("q1_memf_set", rd, 64'h100);
    apb_xfer(12'h04C, 1'b1, 64'h100, 3'b010, 3'b000, rd, err, lat);
    apb_rd(12'h04C, rd, err);
    check("q1_memf_setwins", rd, 64'h100);
    apb_wr(12'h04C, 64'h100, err);
    apb_rd(12'h04C, rd, err);
    check("q1_memf_w1c", rd, 64'h0);

    // Queue 2: log2sz beyond index width saturates the mask.
    apb_wr(12'h038, 64'h1F, err);
    apb_wr(12'h040, 64'hFFFF_FFFF, err);
    check("q2_sat", 64'(q_sw_idx_o[3*IDX_W-1:2*IDX_W]), 64'hFFFFF);

    // Reset while a DDTP write sits in WAIT.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 12'h010; pwrite = 1'b1; pwdata = 64'h2402;
    @(posedge clk); #1;
    penable = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstw_ctl", 64'({pready, pslverr, irq_o, ddtp_busy_o, q_on_o, q_busy_o}), 64'd0);
    check("rstw_ddtp", 64'({ddtp_mode_o, ddtp_ppn_o}), 64'd0);
    check("rstw_q", 64'({|q_ppn_o, |q_log2sz_o, |q_sw_idx_o}), 64'd0);
    apb_rd(12'h010, rd, err);
    check("rstw_ddtp_rd", rd, 64'd0);

`ifdef IOMMU_MMIO_IPSR_EN
    apb_wr(12'h050, 64'h2, err);
    apb_rd(12'h050, rd, err);
    check("ipsr_ie", rd, 64'h2);
    q_int_i = 3'b100;
    @(posedge clk); #1;
    q_int_i = '0;
    check("ipsr_irq_lag", 64'(irq_o), 64'd0);
    @(posedge clk); #1;
    check("ipsr_irq", 64'(irq_o), 64'd1);
    apb_rd(12'h054, rd, err);
    check("ipsr_rd", rd, 64'h4);
    apb_wr(12'h054, 64'h4, err);
    @(posedge clk); #1;
    check("ipsr_irq_clr", 64'(irq_o), 64'd0);
    apb_rd(12'h054, rd, err);
    check("ipsr_rd_clr", rd, 64'h0);
`else
    apb_rd(12'h054, rd, err);
    check("ipsr_unmapped", 64'(err), 64'd1);
    apb_wr(12'h050, 64'h2, err);
    q_int_i = 3'b100;
    @(posedge clk); #1;
    q_int_i = '0;
    @(posedge clk); #1;
    check("irq_tied", 64'(irq_o), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
